// File: rtl/stack_alu_p_if.sv
// stack_alu_p_if: opcode/status bundle between the command decoder and the operand stack
// Ports: in/op/apply carry the command (master drives); tail/empty/full/count/valid/err carry stack status (slave drives)
interface stack_alu_p_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] in;
    logic [2:0]       op;
    logic             apply;
    logic [WIDTH-1:0] tail;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             valid;
    logic             err;
    modport master (output in, op, apply, input tail, empty, full, count, valid, err);
    modport slave  (input in, op, apply, output tail, empty, full, count, valid, err);
endinterface

// File: rtl/stack_alu_p.sv
// stack_alu_p: operand stack executing one push/pop/arithmetic opcode per clock when apply is high
// Ports: clk, rst (async active-high); bus.slave carries in/op/apply and returns tail/empty/full/count/valid/err
module stack_alu_p #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic       clk,
    input logic       rst,
    stack_alu_p_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [2:0] POP = 3'd0, DUP = 3'd1, SWAP = 3'd2, ADD = 3'd3;
    localparam logic [2:0] SUB = 3'd4, PUSH = 3'd5, CLEAR = 3'd6;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt, nxt;
    logic [PTR_W-1:0] wp, tp, np;
    logic [WIDTH-1:0] t, n;
    logic             one, two, room, legal, valid_q, err_q;
    // wp is the first free slot, tp the top, np the one below; they are only used when the op is legal
    assign wp   = PTR_W'(cnt);
    assign tp   = PTR_W'(cnt - CNT_W'(1));
    assign np   = PTR_W'(cnt - CNT_W'(2));
    assign t    = mem[tp];
    assign n    = mem[np];
    assign one  = cnt != '0;
    assign two  = cnt > CNT_W'(1);
    assign room = cnt != FULL_CNT;
    assign legal = (bus.op == POP && one) || (bus.op == DUP && one && room) ||
                   ((bus.op == SWAP || bus.op == ADD || bus.op == SUB) && two) ||
                   (bus.op == PUSH && room) || bus.op == CLEAR;
    assign nxt = (bus.op == DUP || bus.op == PUSH) ? cnt + CNT_W'(1) :
                 (bus.op == POP || bus.op == ADD || bus.op == SUB) ? cnt - CNT_W'(1) :
                 (bus.op == CLEAR) ? '0 : cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (bus.apply) begin
            valid_q <= legal;
            err_q   <= (bus.op == CLEAR) ? 1'b0 : err_q | ~legal;
            if (legal) cnt <= nxt;
        end
    end
    // storage is never reset; entries at or above the pointer are never observed
    always_ff @(posedge clk) begin
        if (bus.apply && legal) begin
            if (bus.op == PUSH) mem[wp] <= bus.in;
            if (bus.op == DUP) mem[wp] <= t;
            if (bus.op == SWAP) begin
                mem[tp] <= n;
                mem[np] <= t;
            end
            if (bus.op == ADD) mem[np] <= n + t;
            if (bus.op == SUB) mem[np] <= n - t;
        end
    end
    assign bus.tail  = one ? t : '0;
    assign bus.empty = ~one;
    assign bus.full  = ~room;
    assign bus.count = cnt;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
endmodule
